cmp_pipe: RTL and testbench



---
 rtl/cmp_pipe_pkg.sv | 53 +++++
 rtl/cmp_pipe_fifo.sv | 76 +++++++
 rtl/cmp_pipe.sv | 124 ++++++++++++
 tb/tb_cmp_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pipe_pkg.sv
// Shared types for the branch-comparison pipe: station entry, result bus,
// queue entry and the branch operation encoding.
package cmp_pipe_pkg;

  localparam int CMP_XLEN  = 32;
  localparam int CMP_TAG_W = 4;

  // Encodings follow the RISC-V funct3 field; 3'd2 and 3'd3 are unused.
  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLT  = 3'd4,
    OP_BGE  = 3'd5,
    OP_BLTU = 3'd6,
    OP_BGEU = 3'd7
  } br_op_e;

  typedef struct packed {
    br_op_e                op;
    logic [CMP_XLEN-1:0]   r1;
    logic [CMP_XLEN-1:0]   r2;
    logic [CMP_TAG_W-1:0]  tag;
  } rs_t;

  typedef struct packed {
    logic [CMP_XLEN-1:0]   data;
    logic [CMP_TAG_W-1:0]  tag;
  } cmp_entry_t;

  typedef struct packed {
    logic [CMP_XLEN-1:0]   data;
    logic [CMP_TAG_W-1:0]  tag;
    logic                  rdy;
  } sal_t;

  function automatic logic br_taken(input br_op_e op,
                                    input logic [CMP_XLEN-1:0] a,
                                    input logic [CMP_XLEN-1:0] b);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQ:  t = (a == b);
      OP_BNE:  t = (a != b);
      OP_BLT:  t = ($signed(a) < $signed(b));
      OP_BGE:  t = ($signed(a) >= $signed(b));
      OP_BLTU: t = (a < b);
      OP_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cmp_pipe_fifo.sv
// Multi-write, single-read circular result queue (DEPTH must be a power of two).
// Set push bits need not be contiguous; they are packed in port order.
module cmp_fifo
  import cmp_pipe_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WR_PORTS = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [WR_PORTS-1:0]       push_i,
  input  cmp_entry_t [WR_PORTS-1:0] wdata_i,
  input  logic                      pop_i,
  output cmp_entry_t                rdata_o,
  output logic [CNT_W-1:0]          count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmp_entry_t       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_push;
  logic [PW-1:0]    n_push_p;
  logic [PW-1:0]    wr_idx [WR_PORTS];
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    n_push   = '0;
    n_push_p = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      wr_idx[w] = wr_ptr_q + n_push_p;
      if (push_i[w]) begin
        n_push   = n_push + 1'b1;
        n_push_p = n_push_p + 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q + n_push_p;
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + n_push - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int w = 0; w < WR_PORTS; w++) begin
        if (push_i[w]) mem_q[wr_idx[w]] <= wdata_i[w];
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cmp_pipe.sv
// Multi-lane branch-comparison pipe: select -> S1 -> compare -> result queue.
// Optional CMP_BYPASS_EN shows S1 lane 0 on out directly when the queue is empty.
module cmp_pipe
  import cmp_pipe_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  rs_t  [SIZE-1:0]     data,
  input  logic [SIZE-1:0]     ready,
  input  logic                flush,
  output logic [SIZE-1:0]     ack,
  output sal_t                out,
  input  logic                out_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(SIZE + DEPTH + LANES + 1) + 1;

  logic [LANES-1:0]        s1_vld_q, s1_vld_d;
  rs_t  [LANES-1:0]        s1_ent_q, s1_ent_d;
  cmp_entry_t [LANES-1:0]  cmp_res;
  logic [LANES-1:0]        push;
  cmp_entry_t              head;
  logic [CNT_W-1:0]        q_count;
  logic                    pop;
  logic [CW-1:0]           s1_count, credits, limit, taken;

  // Credits ignore a same-cycle pop so the queue can never overflow.
  always_comb begin
    s1_count = '0;
    for (int l = 0; l < LANES; l++) s1_count = s1_count + CW'(s1_vld_q[l]);
    credits = CW'(DEPTH) - CW'(q_count) - s1_count;
    limit   = (credits < CW'(LANES)) ? credits : CW'(LANES);
  end

  always_comb begin
    ack      = '0;
    s1_vld_d = '0;
    s1_ent_d = '0;
    taken    = '0;
    if (!rst && !flush) begin
      for (int i = 0; i < SIZE; i++) begin
        if (ready[i] && (taken < limit)) begin
          ack[i] = 1'b1;
          for (int l = 0; l < LANES; l++) begin
            if (taken == CW'(l)) begin
              s1_vld_d[l] = 1'b1;
              s1_ent_d[l] = data[i];
            end
          end
          taken = taken + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= '0;
      s1_ent_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_ent_q <= s1_ent_d;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cmp_res[l].data = {CMP_XLEN{br_taken(s1_ent_q[l].op, s1_ent_q[l].r1, s1_ent_q[l].r2)}};
      cmp_res[l].tag  = s1_ent_q[l].tag;
    end
  end

`ifdef CMP_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass = (q_count == '0) && s1_vld_q[0];
    push   = s1_vld_q;
    if (bypass && out_ready) push[0] = 1'b0;
    out = '0;
    if (bypass) begin
      out.rdy  = 1'b1;
      out.data = cmp_res[0].data;
      out.tag  = cmp_res[0].tag;
    end else if (q_count != '0) begin
      out.rdy  = 1'b1;
      out.data = head.data;
      out.tag  = head.tag;
    end
  end
`else
  always_comb begin
    push = s1_vld_q;
    out  = '0;
    if (q_count != '0) begin
      out.rdy  = 1'b1;
      out.data = head.data;
      out.tag  = head.tag;
    end
  end
`endif

  assign pop = (q_count != '0) && out_ready;

  cmp_fifo #(
    .DEPTH    (DEPTH),
    .WR_PORTS (LANES)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (cmp_res),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (q_count)
  );

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe (SIZE=8, LANES=2, DEPTH=4).
module tb_cmp_pipe;
  import cmp_pipe_pkg::*;

  localparam int SIZE  = 8;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
`ifdef CMP_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              out_ready;
  rs_t  [SIZE-1:0]   data;
  logic [SIZE-1:0]   ready;
  logic [SIZE-1:0]   ack;
  sal_t              dout;

  int errs   = 0;
  int checks = 0;

  cmp_pipe #(.SIZE(SIZE), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .ready     (ready),
    .flush     (flush),
    .ack       (ack),
    .out       (dout),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Station model: acked entries leave the station at the edge.
  task automatic tick();
    logic [SIZE-1:0] a;
    a = ack;
    @(posedge clk);
    #1;
    ready = ready & ~a;
    #1;
  endtask

  task automatic load_entries(input int tag_ofs);
    for (int i = 0; i < SIZE; i++) begin
      data[i].op  = OP_BEQ;
      data[i].r1  = 32'd0;
      data[i].r2  = 32'd0;
      data[i].tag = 4'(i + tag_ofs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; ready = '1;
    load_entries(1);
    #3;
    checks++; if (ack !== 8'h00) begin errs++; $display("FAIL reset_ack: got %h expected %h", ack, 8'h00); end
    checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL reset_rdy: got %b expected 0", dout.rdy); end
    checks++; if (dout.tag !== 4'h0) begin errs++; $display("FAIL reset_tag: got %h expected 0", dout.tag); end
    checks++; if (dout.data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h expected 0", dout.data); end
    ready = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL reset_idle_rdy: got %b expected 0", dout.rdy); end
  endtask

  task automatic test_compare();
    br_op_e      ops  [8] = '{OP_BLT, OP_BLTU, OP_BGE, OP_BGEU, OP_BEQ, OP_BNE, OP_BEQ, br_op_e'(3'd2)};
    logic [31:0] r1v  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd5, 32'd5, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] r2v  [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd5};
    logic        expb [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ed;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data[0].op  = ops[k];
      data[0].r1  = r1v[k];
      data[0].r2  = r2v[k];
      data[0].tag = 4'(k + 1);
      ed = expb[k] ? 32'hFFFF_FFFF : 32'h0;
      ready = 8'h01;
      #1;
      checks++; if (ack !== 8'h01) begin errs++; $display("FAIL cmp%0d_ack: got %h expected 01", k, ack); end
      for (int c = 1; c <= LAT + 1; c++) begin
        tick();
        if (c < LAT) begin
          checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL cmp%0d_early: got rdy %b expected 0", k, dout.rdy); end
        end else if (c == LAT) begin
          checks++; if (dout.rdy !== 1'b1) begin errs++; $display("FAIL cmp%0d_rdy: got %b expected 1", k, dout.rdy); end
          checks++; if (dout.data !== ed) begin errs++; $display("FAIL cmp%0d_data: got %h expected %h", k, dout.data, ed); end
          checks++; if (dout.tag !== 4'(k + 1)) begin errs++; $display("FAIL cmp%0d_tag: got %h expected %h", k, dout.tag, 4'(k + 1)); end
        end else begin
          checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL cmp%0d_drain: got rdy %b expected 0", k, dout.rdy); end
        end
      end
    end
  endtask

  task automatic test_multi_lane();
    logic [3:0] et [4] = '{4'd5, 4'd7, 4'd8, 4'd10};
    load_entries(3);
    out_ready = 1'b1;
    ready = 8'b1011_0100;
    #1;
    checks++; if (ack !== 8'b0001_0100) begin errs++; $display("FAIL ml_ack0: got %b expected 00010100", ack); end
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (ack !== 8'b1010_0000) begin errs++; $display("FAIL ml_ack1: got %b expected 10100000", ack); end
      end
      if (c >= LAT && c <= LAT + 3) begin
        checks++; if (dout.rdy !== 1'b1 || dout.tag !== et[c - LAT])
          begin errs++; $display("FAIL ml_order_c%0d: got rdy %b tag %h expected rdy 1 tag %h", c, dout.rdy, dout.tag, et[c - LAT]); end
      end
      if (c == LAT + 4) begin
        checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL ml_drain: got rdy %b expected 0", dout.rdy); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ea [9] = '{8'h03, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h40, 8'h80};
    load_entries(0);
    out_ready = 1'b0;
    ready = '1;
    for (int c = 0; c <= 12; c++) begin
      out_ready = (c >= 4);
      #1;
      if (c <= 8) begin
        checks++; if (ack !== ea[c]) begin errs++; $display("FAIL bp_ack_c%0d: got %h expected %h", c, ack, ea[c]); end
      end
      if (c == 3) begin
        checks++; if (dout.rdy !== 1'b1 || dout.tag !== 4'h0)
          begin errs++; $display("FAIL bp_hold: got rdy %b tag %h expected rdy 1 tag 0", dout.rdy, dout.tag); end
      end
      if (c >= 4 && c <= 11) begin
        checks++; if (dout.rdy !== 1'b1 || dout.tag !== 4'(c - 4))
          begin errs++; $display("FAIL bp_tag_c%0d: got rdy %b tag %h expected rdy 1 tag %h", c, dout.rdy, dout.tag, 4'(c - 4)); end
      end
      if (c == 12) begin
        checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL bp_drain: got rdy %b expected 0", dout.rdy); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    load_entries(0);
    out_ready = 1'b0;
    ready = '1;
    #1;
    checks++; if (ack !== 8'h03) begin errs++; $display("FAIL fl_ack0: got %h expected 03", ack); end
    tick();
    checks++; if (ack !== 8'h0C) begin errs++; $display("FAIL fl_ack1: got %h expected 0C", ack); end
    tick();
    flush = 1'b1;
    #1;
    checks++; if (ack !== 8'h00) begin errs++; $display("FAIL fl_ack_during: got %h expected 00", ack); end
    checks++; if (dout.rdy !== 1'b1) begin errs++; $display("FAIL fl_pre_rdy: got %b expected 1", dout.rdy); end
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL fl_post_rdy: got %b expected 0", dout.rdy); end
    checks++; if (ack !== 8'h30) begin errs++; $display("FAIL fl_ack_resume: got %h expected 30", ack); end
    for (int c = 4; c <= 3 + LAT + 4; c++) begin
      tick();
      if (c == 4) begin
        checks++; if (ack !== 8'hC0) begin errs++; $display("FAIL fl_ack_c4: got %h expected C0", ack); end
      end
      if (c >= 3 + LAT && c <= 3 + LAT + 3) begin
        checks++; if (dout.rdy !== 1'b1 || dout.tag !== 4'(c - 3 - LAT + 4))
          begin errs++; $display("FAIL fl_tag_c%0d: got rdy %b tag %h expected rdy 1 tag %h", c, dout.rdy, dout.tag, 4'(c - 3 - LAT + 4)); end
      end
      if (c == 3 + LAT + 4) begin
        checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL fl_drain: got rdy %b expected 0", dout.rdy); end
      end
    end
    ready = 8'h01;
    flush = 1'b1;
    #1;
    checks++; if (ack !== 8'h00) begin errs++; $display("FAIL fl_ack_idle: got %h expected 00", ack); end
    tick();
    flush = 1'b0;
    ready = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL fl_idle_rdy_c%0d: got %b expected 0", c, dout.rdy); end
    end
  endtask

  task automatic test_reset_mid();
    load_entries(1);
    out_ready = 1'b0;
    ready = 8'h07;
    #1;
    checks++; if (ack !== 8'h03) begin errs++; $display("FAIL rm_ack0: got %h expected 03", ack); end
    tick();
    checks++; if (ack !== 8'h04) begin errs++; $display("FAIL rm_ack1: got %h expected 04", ack); end
    tick();
    tick();
    checks++; if (dout.rdy !== 1'b1 || dout.tag !== 4'h1)
      begin errs++; $display("FAIL rm_count3_head: got rdy %b tag %h expected rdy 1 tag 1", dout.rdy, dout.tag); end
    ready = 8'h10;
    #1;
    checks++; if (ack !== 8'h10) begin errs++; $display("FAIL rm_ack_credit: got %h expected 10", ack); end
    rst = 1'b1;
    #1;
    checks++; if (ack !== 8'h00) begin errs++; $display("FAIL rm_ack: got %h expected 00", ack); end
    checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL rm_rdy: got %b expected 0", dout.rdy); end
    checks++; if (dout.tag !== 4'h0) begin errs++; $display("FAIL rm_tag: got %h expected 0", dout.tag); end
    checks++; if (dout.data !== 32'h0) begin errs++; $display("FAIL rm_data: got %h expected 0", dout.data); end
    ready = '0;
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (dout.rdy !== 1'b0) begin errs++; $display("FAIL rm_stale_c%0d: got rdy %b tag %h expected rdy 0", c, dout.rdy, dout.tag); end
    end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_multi_lane();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
